// File: rtl/cpu_pkg.sv
// Shared definitions for the phase-1 control path: opcodes, IR field layout
// and the control-step state encoding.
package cpu_pkg;

    localparam int IR_W      = 32;
    localparam int OPC_W     = 5;
    localparam int REG_IDX_W = 4;

    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
    localparam logic [OPC_W-1:0] OP_AND = 5'd2;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SHR = 5'd4;
    localparam logic [OPC_W-1:0] OP_SHL = 5'd5;
    localparam logic [OPC_W-1:0] OP_ROR = 5'd6;
    localparam logic [OPC_W-1:0] OP_ROL = 5'd7;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd8;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd9;
    localparam logic [OPC_W-1:0] OP_NEG = 5'd10;
    localparam logic [OPC_W-1:0] OP_NOT = 5'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier: ALU operation code plus the unary,
// multiply/divide and illegal flags the sequencer branches on.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic [OPC_W-1:0] alu_op_o,
    output logic             is_unary_o,
    output logic             is_muldiv_o,
    output logic             is_illegal_o
);

    always_comb begin
        alu_op_o     = opcode_i;
        is_unary_o   = 1'b0;
        is_muldiv_o  = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: ;
            OP_MUL, OP_DIV:                 is_muldiv_o = 1'b1;
            OP_NEG, OP_NOT:                 is_unary_o  = 1'b1;
            default: begin
                // Illegal codes never reach the ALU as a real operation.
                alu_op_o     = '0;
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control-step sequencer: one fetch plus one register-register
// ALU execute per start, driving every bus-source select and load enable.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_rdy,
    input  logic [IR_W-1:0]     ir,
    output logic [NUM_REGS-1:0] r_out,
    output logic [NUM_REGS-1:0] r_in,
    output logic                pc_out,
    output logic                mdr_out,
    output logic                zlow_out,
    output logic                zhigh_out,
    output logic                pc_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                hi_in,
    output logic                lo_in,
    output logic                inc_pc,
    output logic                read,
    output logic [OPC_W-1:0]    alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    state_e state_q, state_d;
    logic   t1_first_q, t1_first_d;

    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic [REG_IDX_W-1:0] r_out_idx, r_in_idx;
    logic                 r_out_en, r_in_en;

    logic [OPC_W-1:0] dec_alu_op;
    logic             dec_unary, dec_muldiv, dec_illegal;
    logic             ir_unused;

    assign ra        = ir[RA_LSB +: REG_IDX_W];
    assign rb        = ir[RB_LSB +: REG_IDX_W];
    assign rc        = ir[RC_LSB +: REG_IDX_W];
    assign ir_unused = ^ir[RC_LSB-1:0];

    instr_decode u_instr_decode (
        .opcode_i     (ir[OPC_LSB +: OPC_W]),
        .alu_op_o     (dec_alu_op),
        .is_unary_o   (dec_unary),
        .is_muldiv_o  (dec_muldiv),
        .is_illegal_o (dec_illegal)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= S_IDLE;
            t1_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_first_q <= t1_first_d;
        end
    end

    // IR is registered by the datapath, so every opcode-dependent choice is
    // made from T3 onward, never from the value being loaded in T2.
    always_comb begin
        state_d    = state_q;
        t1_first_d = 1'b0;
        r_out_en   = 1'b0;
        r_out_idx  = rb;
        r_in_en    = 1'b0;
        r_in_idx   = ra;
        pc_out     = 1'b0;
        mdr_out    = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        pc_in      = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        alu_op     = '0;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                z_in       = 1'b1;
                t1_first_d = 1'b1;
                state_d    = S_T1;
            end
            S_T1: begin
                // PC+1 is written once; wait cycles only stretch the read.
                zlow_out = 1'b1;
                pc_in    = t1_first_q;
                read     = 1'b1;
                mdr_in   = 1'b1;
                if (mem_rdy) begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    r_out_en = 1'b1;
                    y_in     = !dec_unary;
                    state_d  = S_T4;
                end
            end
            S_T4: begin
                z_in      = 1'b1;
                alu_op    = dec_alu_op;
                r_out_en  = 1'b1;
                r_out_idx = dec_unary ? rb : rc;
                state_d   = S_T5;
            end
            S_T5: begin
                zlow_out = 1'b1;
                if (dec_muldiv) begin
                    lo_in   = 1'b1;
                    state_d = S_T6;
                end else begin
                    r_in_en = 1'b1;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gpr_sel
            assign r_out[gi] = r_out_en && (r_out_idx == REG_IDX_W'(gi));
            assign r_in[gi]  = r_in_en  && (r_in_idx  == REG_IDX_W'(gi));
        end
    endgenerate

    // The bus priority chain must never be the thing that resolves a conflict.
    a_one_bus_source: assert property (@(posedge clock) disable iff (clear)
        $onehot0({pc_out, mdr_out, zlow_out, zhigh_out, |r_out}) && $onehot0(r_out));

    a_one_gpr_load: assert property (@(posedge clock) disable iff (clear)
        $onehot0(r_in));

    a_done_illegal_exclusive: assert property (@(posedge clock) disable iff (clear)
        !(done && illegal));

endmodule
